// File: rtl/hop_chain_sequencer.sv
// Stimulus/checker for the 4-flop hop chain: staggered reset release, LFSR stream on start, ff4 check.
// Optional HOP_SEQ_ERR_INJECT_EN adds input inj, which inverts the expected bit of a valid comparison.
module hop_chain_sequencer #(
  parameter int HOLD_CYCLES = 4,
  parameter int STAGGER     = 2,
  parameter int CHAIN_LAT   = 4,
  parameter int RUN_CYCLES  = 256,
  parameter int ERR_W       = 8
) (
  input  logic             clock0,
  input  logic             rst0_n,
  input  logic             go,
`ifdef HOP_SEQ_ERR_INJECT_EN
  input  logic             inj,
`endif
  output logic             rst1,
  output logic             rst2,
  output logic             rst3,
  output logic             start,
  input  logic             ff4,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [2:0]       fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HOLD  = 3'd1,
    S_REL   = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam int CNT_W = $clog2(HOLD_CYCLES + 3 * STAGGER + RUN_CYCLES + CHAIN_LAT + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REL_R2     = CNT_W'(STAGGER - 1);
  localparam logic [CNT_W-1:0] REL_R3     = CNT_W'(2 * STAGGER - 1);
  localparam logic [CNT_W-1:0] REL_LAST   = CNT_W'(3 * STAGGER - 1);
  localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(RUN_CYCLES);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(CHAIN_LAT - 1);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [7:0]           lfsr;
  logic [7:0]           lfsr_next;
  logic [CHAIN_LAT-1:0] exp_pipe;
  logic [CHAIN_LAT-1:0] vld_pipe;
  logic                 inj_bit;
  logic                 mismatch;
  logic [ERR_W-1:0]     err_next;

  assign fsm_state = state;

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1; the issued bit is lfsr[0] before the shift.
  assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

`ifdef HOP_SEQ_ERR_INJECT_EN
  assign inj_bit = inj;
`else
  assign inj_bit = 1'b0;
`endif

  assign mismatch = vld_pipe[CHAIN_LAT-1] && (ff4 != (exp_pipe[CHAIN_LAT-1] ^ inj_bit));

  always_comb begin
    err_next = err_count;
    if (mismatch && (err_count != {ERR_W{1'b1}})) err_next = err_count + 1'b1;
  end

  always_ff @(posedge clock0 or negedge rst0_n) begin
    if (!rst0_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      lfsr      <= 8'h01;
      exp_pipe  <= '0;
      vld_pipe  <= '0;
      rst1      <= 1'b1;
      rst2      <= 1'b1;
      rst3      <= 1'b1;
      start     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
    end else begin
      exp_pipe  <= CHAIN_LAT'({exp_pipe, start});
      vld_pipe  <= CHAIN_LAT'({vld_pipe, state == S_RUN});
      err_count <= err_next;
      case (state)
        S_IDLE, S_DONE: begin
          if (go) begin
            state     <= S_HOLD;
            cnt       <= '0;
            lfsr      <= 8'h01;
            exp_pipe  <= '0;
            vld_pipe  <= '0;
            err_count <= '0;
            rst1      <= 1'b1;
            rst2      <= 1'b1;
            rst3      <= 1'b1;
            start     <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
          end
        end
        S_HOLD: begin
          if (cnt == HOLD_LAST) begin
            state <= S_REL;
            cnt   <= '0;
            rst1  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_REL: begin
          cnt <= cnt + 1'b1;
          if (cnt == REL_R2) rst2 <= 1'b0;
          if (cnt == REL_R3) rst3 <= 1'b0;
          // The first stream bit is issued on the edge that enters RUN, so start is aligned with RUN.
          if (cnt == REL_LAST) begin
            state <= S_RUN;
            cnt   <= CNT_W'(1);
            start <= lfsr[0];
            lfsr  <= lfsr_next;
          end
        end
        S_RUN: begin
          if (cnt == RUN_LAST) begin
            state <= S_DRAIN;
            cnt   <= '0;
            start <= 1'b0;
          end else begin
            start <= lfsr[0];
            lfsr  <= lfsr_next;
            cnt   <= cnt + 1'b1;
          end
        end
        S_DRAIN: begin
          if (cnt == DRAIN_LAST) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            // err_next includes a mismatch found in this final cycle.
            pass  <= (err_next == '0);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hop_chain_sequencer.sv
// Directed bench for hop_chain_sequencer: scenario table plus hand sequences for reset, go handling
// and saturation. The injection scenario is included when HOP_SEQ_ERR_INJECT_EN is defined.
module tb_hop_chain_sequencer;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_HOLD = 3'd1, ST_RUN = 3'd3, ST_DONE = 3'd5;
  // Cycle offsets from HOLD entry for the default parameters: 4 hold, 2-cycle stagger, 256 run, 4 drain.
  localparam int T_RST1 = 4, T_RST2 = 6, T_RST3 = 8, T_RUN = 10, T_DONE = 270;
  localparam logic [1:0] M_IDEAL = 2'd0, M_STUCK0 = 2'd1, M_INV = 2'd2;

  logic       clock0 = 1'b0;
  logic       rst0_n = 1'b0;
  logic       go = 1'b0;
  logic       inj = 1'b0;
  logic       rst1, rst2, rst3, start, ff4, busy, done, pass;
  logic [7:0] err_count;
  logic [2:0] fsm_state;

  logic       go2 = 1'b0;
  logic       inj2 = 1'b0;
  logic       rst1_2, rst2_2, rst3_2, start2, ff4_2, busy2, done2, pass2;
  logic [3:0] err_count2;
  logic [2:0] fsm_state2;

  always #5 clock0 = ~clock0;

  hop_chain_sequencer dut (
    .clock0(clock0), .rst0_n(rst0_n), .go(go),
`ifdef HOP_SEQ_ERR_INJECT_EN
    .inj(inj),
`endif
    .rst1(rst1), .rst2(rst2), .rst3(rst3), .start(start), .ff4(ff4),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count), .fsm_state(fsm_state)
  );

  hop_chain_sequencer #(.ERR_W(4)) dut2 (
    .clock0(clock0), .rst0_n(rst0_n), .go(go2),
`ifdef HOP_SEQ_ERR_INJECT_EN
    .inj(inj2),
`endif
    .rst1(rst1_2), .rst2(rst2_2), .rst3(rst3_2), .start(start2), .ff4(ff4_2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err_count2), .fsm_state(fsm_state2)
  );

  // Chain models: ff4 in cycle t+4 is start from cycle t, optionally corrupted.
  logic [1:0] chain_mode = M_IDEAL;
  logic [3:0] dly = '0;
  logic [3:0] dly2 = '0;
  always @(posedge clock0) begin
    dly  <= {dly[2:0], start};
    dly2 <= {dly2[2:0], start2};
  end
  always_comb begin
    ff4 = dly[3];
    if (chain_mode == M_STUCK0) ff4 = 1'b0;
    else if (chain_mode == M_INV) ff4 = ~dly[3];
  end
  assign ff4_2 = ~dly2[3];

  // Scoreboard state
  int           n_checks = 0;
  int           n_errors = 0;
  logic [0:0]   exp_q[$];
  logic [255:0] model_vec;
  logic [255:0] got_vec;
  logic [255:0] first_vec;
  int           res_rst1_k, res_rst2_k, res_rst3_k, res_run_k, res_done_k, res_bits;
  int           res_relapse, res_mism, res_extra, res_k0_busy;

  typedef struct {
    logic [1:0] mode;
    int         extra_go_k;
    int         inj_lo;
    int         inj_hi;
    int         exp_err;
    logic       exp_pass;
  } vec_t;
  vec_t vecs[6];
  int   n_vec;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [255:0] gen_stream();
    logic [7:0]   l;
    logic [255:0] v;
    l = 8'h01;
    for (int i = 0; i < 256; i++) begin
      v[i] = l[0];
      l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    end
    return v;
  endfunction

  task automatic wait_done(input int budget, input string name);
    int k;
    k = 0;
    while (!done && k < budget) begin
      @(negedge clock0);
      k++;
    end
    check(name, done, 1);
  endtask

  // Pulses go, then observes every cycle until done (bounded), recording event offsets from HOLD entry.
  task automatic run_test(input int extra_go_k, input int inj_lo, input int inj_hi);
    int k;
    logic [0:0] e;
    res_rst1_k = -1; res_rst2_k = -1; res_rst3_k = -1; res_run_k = -1;
    res_bits = 0; res_relapse = 0; res_mism = 0; res_extra = 0;
    got_vec = '0;
    exp_q.delete();
    for (int i = 0; i < 256; i++) exp_q.push_back(model_vec[i]);
    @(negedge clock0); go = 1'b1;
    @(negedge clock0); go = 1'b0;
    res_k0_busy = (busy === 1'b1 && fsm_state === ST_HOLD && rst1 && rst2 && rst3) ? 1 : 0;
    k = 0;
    while (!done && k < 2000) begin
      if (rst1 === 1'b0 && res_rst1_k < 0) res_rst1_k = k;
      if (rst2 === 1'b0 && res_rst2_k < 0) res_rst2_k = k;
      if (rst3 === 1'b0 && res_rst3_k < 0) res_rst3_k = k;
      if (k >= T_RST3 && (rst1 || rst2 || rst3)) res_relapse++;
      if (fsm_state === ST_RUN) begin
        if (res_run_k < 0) res_run_k = k;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          if (start !== e[0]) res_mism++;
        end else begin
          res_extra++;
        end
        if (res_bits < 256) got_vec[res_bits] = start;
        res_bits++;
      end
      go  = (k == extra_go_k);
      inj = (k >= inj_lo && k <= inj_hi);
      @(negedge clock0);
      k++;
    end
    go = 1'b0;
    inj = 1'b0;
    res_done_k = k;
    check("done_within_budget", done, 1);
  endtask

  initial begin
    model_vec = gen_stream();

    n_vec = 0;
    vecs[n_vec++] = '{M_IDEAL,  -1, -1, -1, 0,                      1'b1};
    vecs[n_vec++] = '{M_STUCK0, -1, -1, -1, $countones(model_vec), 1'b0};
    vecs[n_vec++] = '{M_INV,    -1, -1, -1, 255,                    1'b0};
    vecs[n_vec++] = '{M_IDEAL,  50, -1, -1, 0,                      1'b1};
    vecs[n_vec++] = '{M_IDEAL,  -1, -1, -1, 0,                      1'b1};
`ifdef HOP_SEQ_ERR_INJECT_EN
    vecs[n_vec++] = '{M_IDEAL,  -1, 20, 22, 3,                      1'b0};
`endif

    // Reset state
    repeat (2) @(negedge clock0);
    check("reset_rst1", rst1, 1);
    check("reset_rst2", rst2, 1);
    check("reset_rst3", rst3, 1);
    check("reset_start", start, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_pass", pass, 0);
    check("reset_err", err_count, 0);
    check("reset_state", fsm_state, ST_IDLE);
    rst0_n = 1'b1;
    repeat (3) @(negedge clock0);
    check("idle_no_go_state", fsm_state, ST_IDLE);

    for (int v = 0; v < n_vec; v++) begin
      chain_mode = vecs[v].mode;
      run_test(vecs[v].extra_go_k, vecs[v].inj_lo, vecs[v].inj_hi);
      check($sformatf("v%0d_hold_entry", v), res_k0_busy, 1);
      check($sformatf("v%0d_rst1_fall", v), res_rst1_k, T_RST1);
      check($sformatf("v%0d_rst2_fall", v), res_rst2_k, T_RST2);
      check($sformatf("v%0d_rst3_fall", v), res_rst3_k, T_RST3);
      check($sformatf("v%0d_run_entry", v), res_run_k, T_RUN);
      check($sformatf("v%0d_done_cycle", v), res_done_k, T_DONE);
      check($sformatf("v%0d_run_bits", v), res_bits, 256);
      check($sformatf("v%0d_rst_low_after_release", v), res_relapse, 0);
      check($sformatf("v%0d_start_stream_mism", v), res_mism + res_extra + exp_q.size(), 0);
      check($sformatf("v%0d_err_count", v), err_count, vecs[v].exp_err);
      check($sformatf("v%0d_pass", v), pass, vecs[v].exp_pass);
      check($sformatf("v%0d_busy_in_done", v), busy, 0);
      check($sformatf("v%0d_state_done", v), fsm_state, ST_DONE);
      check($sformatf("v%0d_rst_in_done", v), {rst1, rst2, rst3}, 0);
      if (v == 0) begin
        first_vec = got_vec;
      end else begin
        n_checks++;
        if (got_vec !== first_vec) begin
          n_errors++;
          $display("FAIL v%0d_start_same_as_first: got %h, expected %h", v, got_vec, first_vec);
        end
      end
    end

    // DONE outputs hold while go stays low
    repeat (5) @(negedge clock0);
    check("done_holds_done", done, 1);
    check("done_holds_state", fsm_state, ST_DONE);

    // go held high: each entry into DONE restarts immediately
    chain_mode = M_IDEAL;
    go = 1'b1;
    @(negedge clock0);
    check("go_held_restart1_busy", busy, 1);
    check("go_held_restart1_state", fsm_state, ST_HOLD);
    wait_done(400, "go_held_first_done");
    check("go_held_done_pass", pass, 1);
    @(negedge clock0);
    check("go_held_restart2_busy", busy, 1);
    check("go_held_restart2_done", done, 0);
    go = 1'b0;
    wait_done(400, "go_held_final_done");
    check("go_held_final_err", err_count, 0);

    // Asynchronous reset mid-RUN, with errors already counted
    chain_mode = M_STUCK0;
    @(negedge clock0); go = 1'b1;
    @(negedge clock0); go = 1'b0;
    repeat (T_RUN + 30) @(negedge clock0);
    check("midrun_state_run", fsm_state, ST_RUN);
    check("midrun_err_nonzero", (err_count != 0), 1);
    #2 rst0_n = 1'b0;
    #1;
    check("async_rst_rst1", rst1, 1);
    check("async_rst_rst2", rst2, 1);
    check("async_rst_rst3", rst3, 1);
    check("async_rst_start", start, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_err", err_count, 0);
    check("async_rst_state", fsm_state, ST_IDLE);
    @(negedge clock0);
    rst0_n = 1'b1;
    chain_mode = M_IDEAL;
    run_test(-1, -1, -1);
    check("after_rst_err", err_count, 0);
    check("after_rst_pass", pass, 1);
    check("after_rst_done_cycle", res_done_k, T_DONE);

    // 4-bit error counter with inverted chain must saturate at 15
    @(negedge clock0); go2 = 1'b1;
    @(negedge clock0); go2 = 1'b0;
    for (int k = 0; k < 400 && !done2; k++) @(negedge clock0);
    check("sat_done", done2, 1);
    check("sat_err_count", err_count2, 15);
    check("sat_pass", pass2, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hop_chain_sequencer.md
Name: hop_chain_sequencer

Overview:
- Stimulus and checker stage that sits directly upstream of the 4-flop hop chain benchmark.
- Drives the chain's three active-high resets and its `start` input, and consumes the chain output `ff4`.
- Releases the chain resets in a staggered order, then streams a pseudo-random bit pattern into `start`.
- Checks that `ff4` reproduces the pattern after CHAIN_LAT cycles, counts mismatches and reports pass/fail.

Parameters:
- HOLD_CYCLES, 4: cycles all chain resets stay asserted after `go` (must be ≥1).
- STAGGER, 2: cycles between successive reset releases, in the order rst1, rst2, rst3 (must be ≥1).
- CHAIN_LAT, 4: chain latency in cycles, from the `start` register output to `ff4`.
- RUN_CYCLES, 256: number of stimulus bits issued per test.
- ERR_W, 8: width of the error counter.

Ports:
- clock0  in  1  single clock, rising edge.
- rst0_n  in  1  asynchronous, active-low reset.
- go  in  1  launch test; sampled only in IDLE or DONE.
- rst1  out  1  chain reset 1, active high, registered.
- rst2  out  1  chain reset 2, active high, registered.
- rst3  out  1  chain reset 3, active high, registered.
- start  out  1  chain stimulus bit, registered.
- ff4  in  1  chain output returned to the checker.
- busy  out  1  high from the HOLD state through the DRAIN state.
- done  out  1  high in DONE.
- pass  out  1  valid while done=1; 1 means err_count is 0.
- err_count  out  ERR_W  mismatch count, saturating.

Behaviour:
- Reset, asynchronous on rst0_n low, applies immediately even mid-test:
  - rst1 = rst2 = rst3 = 1, so the chain is held.
  - start = 0, busy = 0, done = 0, pass = 0, err_count = 0.
  - LFSR = 8'h01, expected pipe and valid pipe cleared, state = IDLE.
- FSM states: IDLE, HOLD, REL, RUN, DRAIN, DONE.
  - IDLE: go=1 → HOLD; clear err_count, seed LFSR to 8'h01, clear the pipes.
  - HOLD: rst1..3 = 1 for HOLD_CYCLES cycles → REL.
  - REL: rst1 drops on the first cycle, rst2 STAGGER cycles later, rst3 STAGGER cycles after rst2. After rst3 has been low for STAGGER cycles → RUN. start = 0 throughout.
  - RUN: each cycle, start ← LFSR[0] and the LFSR advances (Fibonacci, taps x^8+x^6+x^5+x^4+1). After exactly RUN_CYCLES bits → DRAIN.
  - DRAIN: start = 0 for CHAIN_LAT cycles while the checker keeps comparing → DONE.
  - DONE: done = 1, busy = 0, pass = (err_count == 0). Outputs hold. go=1 → HOLD, starting a new test.
- Checker:
  - exp_pipe is CHAIN_LAT deep and loads start each cycle. vld_pipe loads (state == RUN) alongside it.
  - Each cycle, if vld_pipe[CHAIN_LAT-1] = 1 and ff4 ≠ exp_pipe[CHAIN_LAT-1], err_count increments at the next edge.
  - err_count saturates at 2^ERR_W − 1.
- Boundaries:
  - go while busy is ignored.
  - go held high through DONE restarts every time DONE is entered.
  - Mismatches in the final DRAIN cycle are counted before done asserts.
  - rst1..3 stay low during RUN, DRAIN and DONE.
- Latency: a start bit issued in cycle t is compared against ff4 in cycle t+CHAIN_LAT.
- All outputs come straight from flops; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro HOP_SEQ_ERR_INJECT_EN.
- When defined:
  - Adds input port inj (1 bit).
  - When inj = 1 in a cycle where a comparison is valid, the expected bit is inverted for that comparison, forcing one counted error.
  - Used to prove the checker path on silicon.
- When undefined: port inj is absent and the comparison is unmodified.

Test Plan:
- Reset, then go pulse with ideal chain (ff4 = start delayed 4 cycles) → rst1 falls 4 cycles after HOLD entry, rst2 2 cycles later, rst3 2 cycles after that; done after 256 RUN + 4 DRAIN cycles; pass = 1, err_count = 0.
- Chain model with ff4 stuck at 0 → err_count equals the number of ones among the first 256 LFSR bits seeded 8'h01; pass = 0.
- ERR_W = 4 with ff4 inverted → err_count saturates at 15 and does not wrap.
- rst0_n driven low mid-RUN → in the same cycle rst1..3 = 1, start = 0, busy = 0, err_count = 0, state IDLE; a new go yields pass = 1.
- go pulsed during RUN, then go in DONE → no restart during RUN; a second complete test runs and the start sequence is identical to the first (same seed).
- HOP_SEQ_ERR_INJECT_EN defined, ideal chain, inj pulsed for 3 valid cycles → err_count = 3, pass = 0.
